// File: rtl/vip_raw8_pattern_gen.sv
// vip_raw8_pattern_gen
// Synthetic Bayer (BGGR) RAW8 sensor source with sensor-style vsync/href timing.
// It replaces the camera at the RAW8 input of the frame-difference pipeline for
// bring-up and self-test. Once started it runs frame after frame, and it only
// stops at a frame boundary.
//
// Ports
//   clk              : pixel clock
//   rst_n            : synchronous reset, active low
//   enable           : run request; sampled in IDLE to start, and at end of frame to continue
//   pattern_sel[1:0] : 0 colour bars, 1 gradient, 2 moving box, 3 flat; latched at frame start
//   post_frame_vsync : vsync, active high, for the first VSYNC_LEN lines of a frame
//   post_frame_href  : line valid, active high, during active pixels
//   post_img_RAW[7:0]: Bayer pixel; 0 whenever href is low
//   frame_cnt[15:0]  : number of completed frames, wraps at 16 bits
module vip_raw8_pattern_gen #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int H_BLANK   = 160,
  parameter int VSYNC_LEN = 3,
  parameter int V_BACK    = 17,
  parameter int V_FRONT   = 10,
  parameter int BOX_SIZE  = 32,
  parameter int BOX_STEP  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic [7:0]  post_img_RAW,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = IMG_HDISP + H_BLANK;
  localparam int V_TOTAL = VSYNC_LEN + V_BACK + IMG_VDISP + V_FRONT;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = IMG_HDISP / 8;

  localparam logic [HW-1:0] H_MAX      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(IMG_HDISP);
  localparam logic [VW-1:0] V_MAX      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END = VW'(VSYNC_LEN);
  localparam logic [VW-1:0] V_ACT_BEG  = VW'(VSYNC_LEN + V_BACK);
  localparam logic [VW-1:0] V_ACT_END  = VW'(VSYNC_LEN + V_BACK + IMG_VDISP);
  localparam logic [VW-1:0] BOX_Y      = VW'(IMG_VDISP / 2 - BOX_SIZE / 2);
  localparam logic [VW-1:0] BOX_Y_END  = VW'(IMG_VDISP / 2 - BOX_SIZE / 2 + BOX_SIZE);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_reg, state_next;
  logic [HW-1:0]   h_cnt_reg, h_cnt_next;
  logic [VW-1:0]   v_cnt_reg, v_cnt_next;
  logic [HW-1:0]   box_x_reg, box_x_next;
  logic [15:0]     frame_cnt_reg, frame_cnt_next;
  logic [1:0]      pat_reg, pat_next;
  logic            vsync_reg, vsync_next;
  logic            href_reg, href_next;
  logic [7:0]      raw_reg, raw_next;

  // One comparator per bar boundary; the bar index is how many boundaries x has passed.
  logic [6:0]      bar_ge;
  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_bar
      assign bar_ge[gi-1] = (h_cnt_reg >= HW'(gi * BAR_W));
    end
  endgenerate

  // One extra bit so box_x + BOX_SIZE (or + BOX_STEP + BOX_SIZE) cannot overflow.
  logic [HW:0] box_x_end;
  logic [HW:0] box_x_probe;
  assign box_x_end   = {1'b0, box_x_reg} + (HW+1)'(BOX_SIZE);
  assign box_x_probe = {1'b0, box_x_reg} + (HW+1)'(BOX_STEP + BOX_SIZE);

  // State and data registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      h_cnt_reg     <= '0;
      v_cnt_reg     <= '0;
      box_x_reg     <= '0;
      frame_cnt_reg <= '0;
      pat_reg       <= '0;
      vsync_reg     <= 1'b0;
      href_reg      <= 1'b0;
      raw_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      h_cnt_reg     <= h_cnt_next;
      v_cnt_reg     <= v_cnt_next;
      box_x_reg     <= box_x_next;
      frame_cnt_reg <= frame_cnt_next;
      pat_reg       <= pat_next;
      vsync_reg     <= vsync_next;
      href_reg      <= href_next;
      raw_reg       <= raw_next;
    end
  end

  // Next-state: raster counters, frame-boundary bookkeeping, pattern latch
  always_comb begin
    state_next     = state_reg;
    h_cnt_next     = h_cnt_reg;
    v_cnt_next     = v_cnt_reg;
    box_x_next     = box_x_reg;
    frame_cnt_next = frame_cnt_reg;
    pat_next       = pat_reg;
    case (state_reg)
      IDLE: begin
        h_cnt_next = '0;
        v_cnt_next = '0;
        if (enable) state_next = RUN;
      end
      RUN: begin
        if (h_cnt_reg == '0 && v_cnt_reg == '0) pat_next = pattern_sel;
        if (h_cnt_reg == H_MAX) begin
          h_cnt_next = '0;
          if (v_cnt_reg == V_MAX) begin
            // End of frame: enable is only honoured here, so frames are never cut short.
            v_cnt_next     = '0;
            frame_cnt_next = frame_cnt_reg + 16'd1;
            if (box_x_probe > (HW+1)'(IMG_HDISP)) box_x_next = '0;
            else                                  box_x_next = box_x_reg + HW'(BOX_STEP);
            state_next     = enable ? RUN : IDLE;
          end else begin
            v_cnt_next = v_cnt_reg + 1'b1;
          end
        end else begin
          h_cnt_next = h_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: sync and pixel values for the current counters, registered one cycle later
  always_comb begin
    logic [VW-1:0] y_pix;
    logic [2:0]    bar_idx;
    logic          site_on;
    vsync_next = 1'b0;
    href_next  = 1'b0;
    raw_next   = '0;
    y_pix      = v_cnt_reg - V_ACT_BEG;
    bar_idx    = 3'd0;
    for (int i = 0; i < 7; i++) bar_idx = bar_idx + {2'b00, bar_ge[i]};
    // Bar colours in order white..black give R = ~bar[1], G = ~bar[2], B = ~bar[0].
    case ({y_pix[0], h_cnt_reg[0]})
      2'b00:   site_on = ~bar_idx[0];
      2'b11:   site_on = ~bar_idx[1];
      default: site_on = ~bar_idx[2];
    endcase
    if (state_reg == RUN) begin
      vsync_next = (v_cnt_reg < V_SYNC_END);
      href_next  = (v_cnt_reg >= V_ACT_BEG) && (v_cnt_reg < V_ACT_END) && (h_cnt_reg < H_ACT);
      if (href_next) begin
        case (pat_reg)
          2'd0: raw_next = {8{site_on}};
          2'd1: raw_next = 8'(h_cnt_reg);
          2'd2: raw_next = ((h_cnt_reg >= box_x_reg) && ({1'b0, h_cnt_reg} < box_x_end) &&
                            (y_pix >= BOX_Y) && (y_pix < BOX_Y_END)) ? 8'd240 : 8'd16;
          default: raw_next = 8'h80;
        endcase
      end
    end
  end

  assign post_frame_vsync = vsync_reg;
  assign post_frame_href  = href_reg;
  assign post_img_RAW     = raw_reg;
  assign frame_cnt        = frame_cnt_reg;

endmodule

// File: tb/tb_vip_raw8_pattern_gen.sv
module tb_vip_raw8_pattern_gen;

  // Reduced geometry so a run of several frames stays short.
  localparam int HD  = 64;
  localparam int HB  = 16;
  localparam int VD  = 48;
  localparam int VS  = 3;
  localparam int VB  = 5;
  localparam int VF  = 4;
  localparam int BS  = 8;
  localparam int BST = 12;
  localparam int HT  = HD + HB;
  localparam int VT  = VS + VB + VD + VF;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic        post_frame_vsync;
  logic        post_frame_href;
  logic [7:0]  post_img_RAW;
  logic [15:0] frame_cnt;

  int checks = 0;
  int failures = 0;

  vip_raw8_pattern_gen #(
    .IMG_HDISP(HD), .IMG_VDISP(VD), .H_BLANK(HB), .VSYNC_LEN(VS),
    .V_BACK(VB), .V_FRONT(VF), .BOX_SIZE(BS), .BOX_STEP(BST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
    .post_img_RAW(post_img_RAW), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  function automatic int exp_pix(int x, int y, int pat, int box);
    int rt[8] = '{1, 1, 0, 0, 1, 1, 0, 0};
    int gt[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    int bt[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    int bar;
    int by;
    by = VD / 2 - BS / 2;
    case (pat)
      0: begin
        bar = x / (HD / 8);
        if (y % 2 == 0 && x % 2 == 0)      return bt[bar] * 255;
        else if (y % 2 == 1 && x % 2 == 1) return rt[bar] * 255;
        else                               return gt[bar] * 255;
      end
      1: return x % 256;
      2: return (x >= box && x < box + BS && y >= by && y < by + BS) ? 240 : 16;
      default: return 128;
    endcase
  endfunction

  bit m_valid = 0;
  bit m_run = 0;
  int m_pos = 0, m_frame = 0, m_box = 0, m_pat = 0;
  int e_vs = 0, e_hr = 0, e_raw = 0;

  always @(posedge clk) begin
    int line, col;
    m_valid = 1;
    if (!rst_n) begin
      m_run = 0; m_pos = 0; m_frame = 0; m_box = 0; m_pat = 0;
      e_vs = 0; e_hr = 0; e_raw = 0;
    end else if (m_run) begin
      if (m_pos == 0) m_pat = pattern_sel;
      line  = m_pos / HT;
      col   = m_pos % HT;
      e_vs  = (line < VS) ? 1 : 0;
      e_hr  = (line >= VS + VB && line < VS + VB + VD && col < HD) ? 1 : 0;
      e_raw = e_hr ? exp_pix(col, line - VS - VB, m_pat, m_box) : 0;
      if (m_pos == FRAME - 1) begin
        m_pos   = 0;
        m_frame = (m_frame + 1) % 65536;
        m_box   = (m_box + BST + BS > HD) ? 0 : m_box + BST;
        m_run   = enable;
      end else begin
        m_pos++;
      end
    end else begin
      e_vs = 0; e_hr = 0; e_raw = 0;
      if (enable) m_run = 1;
    end
  end

  // Every-cycle compare against the model
  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (post_frame_vsync !== 1'(e_vs) || post_frame_href !== 1'(e_hr) ||
          post_img_RAW !== 8'(e_raw) || frame_cnt !== 16'(m_frame)) begin
        failures++;
        $display("FAIL model_cycle t=%0t got vs=%0b hr=%0b raw=%0d fc=%0d expected vs=%0d hr=%0d raw=%0d fc=%0d",
                 $time, post_frame_vsync, post_frame_href, post_img_RAW, frame_cnt,
                 e_vs, e_hr, e_raw, m_frame);
      end
    end
  end

  // ---------------- directed checks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  int pix[VD][HD];
  int vs_hi, pulses, min_len, max_len, min_gap, max_gap, vfall, first_href;

  // Captures one frame window of FRAME samples starting at a vsync rise.
  // act_kind: 0 none, 1 set pattern_sel to act_val, 2 drop enable; done when active line act_line starts.
  task automatic capture(input bit started, input int act_line, input int act_kind,
                         input logic [1:0] act_val, input int exp_fc, input string tag,
                         output int rise_wait);
    int line, x, run, gap_run;
    bit prev_vs, prev_hr, vs, hr;
    rise_wait = 0;
    for (int r = 0; r < VD; r++) for (int c = 0; c < HD; c++) pix[r][c] = -1;
    vs_hi = started ? 1 : 0; pulses = 0; min_len = 1 << 30; max_len = 0;
    min_gap = 1 << 30; max_gap = 0; vfall = -1; first_href = -1;
    line = -1; x = 0; run = 0; gap_run = 0; prev_hr = 0;
    if (!started) begin
      prev_vs = post_frame_vsync;
      forever begin
        @(negedge clk);
        rise_wait++;
        if (post_frame_vsync && !prev_vs) break;
        prev_vs = post_frame_vsync;
        if (rise_wait > 2 * FRAME) begin
          chk({tag, "_vsync_rise_timeout"}, 0, 1);
          return;
        end
      end
      prev_vs = 0;
    end else begin
      prev_vs = 1;
    end
    for (int i = started ? 1 : 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      vs = post_frame_vsync;
      hr = post_frame_href;
      if (vs) vs_hi++;
      if (!vs && prev_vs && vfall < 0) vfall = i;
      if (hr && !prev_hr) begin
        line++; x = 0; run = 0;
        if (pulses > 0) begin
          if (gap_run < min_gap) min_gap = gap_run;
          if (gap_run > max_gap) max_gap = gap_run;
        end
        pulses++;
        if (first_href < 0) first_href = i;
        if (line == act_line) begin
          if (act_kind == 1) pattern_sel = act_val;
          if (act_kind == 2) enable = 1'b0;
        end
      end
      if (hr) begin
        if (line < VD && x < HD) pix[line][x] = int'(post_img_RAW);
        x++; run++; gap_run = 0;
      end else begin
        if (prev_hr) begin
          if (run < min_len) min_len = run;
          if (run > max_len) max_len = run;
        end
        gap_run++;
      end
      prev_vs = vs;
      prev_hr = hr;
    end
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_fc));
    $display("frame %s captured: href_pulses=%0d vsync_cycles=%0d frame_cnt=%0d", tag, pulses, vs_hi, frame_cnt);
  endtask

  task automatic check_start(input string tag);
    @(negedge clk);
    chk({tag, "_vsync_after_k"}, 32'(post_frame_vsync), 0);
    @(negedge clk);
    chk({tag, "_vsync_after_k1"}, 32'(post_frame_vsync), 1);
  endtask

  initial begin
    int w;
    int n_vs, n_hr;
    rst_n = 1'b0; enable = 1'b0; pattern_sel = 2'd2;
    repeat (4) @(negedge clk);
    chk("reset_vsync", 32'(post_frame_vsync), 0);
    chk("reset_href", 32'(post_frame_href), 0);
    chk("reset_raw", 32'(post_img_RAW), 0);
    chk("reset_frame_cnt", 32'(frame_cnt), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_vsync", 32'(post_frame_vsync), 0);

    // Frame 0: moving box at x = 0, rows 20..27
    enable = 1'b1;
    check_start("start");
    capture(1'b1, -1, 0, 2'd0, 1, "f0_box", w);
    chk("f0_box_y19_x0", pix[19][0], 16);
    chk("f0_box_y20_x0", pix[20][0], 240);
    chk("f0_box_y20_x7", pix[20][7], 240);
    chk("f0_box_y20_x8", pix[20][8], 16);
    chk("f0_box_y27_x0", pix[27][0], 240);
    chk("f0_box_y28_x0", pix[28][0], 16);

    // Frame 1: box at x = 12; request bars for the following frame
    capture(1'b0, 0, 1, 2'd0, 2, "f1_box", w);
    chk("f1_box_y20_x11", pix[20][11], 16);
    chk("f1_box_y20_x12", pix[20][12], 240);
    chk("f1_box_y20_x19", pix[20][19], 240);
    chk("f1_box_y20_x20", pix[20][20], 16);

    // Frame 2: colour bars plus frame timing
    capture(1'b0, -1, 0, 2'd0, 3, "f2_bars", w);
    chk("bars_y0_x0_white_B", pix[0][0], 255);
    chk("bars_y0_x8_yellow_B", pix[0][8], 0);
    chk("bars_y0_x9_yellow_G", pix[0][9], 255);
    chk("bars_y0_x63_black", pix[0][63], 0);
    chk("bars_y1_x49_blue_R", pix[1][49], 0);
    chk("bars_y1_x1_white_R", pix[1][1], 255);
    chk("timing_vsync_cycles", 32'(vs_hi), 32'(VS * HT));
    chk("timing_href_pulses", 32'(pulses), 32'(VD));
    chk("timing_href_min_len", 32'(min_len), 32'(HD));
    chk("timing_href_max_len", 32'(max_len), 32'(HD));
    chk("timing_gap_min", 32'(min_gap), 32'(HB));
    chk("timing_gap_max", 32'(max_gap), 32'(HB));
    chk("timing_vfall_to_href", 32'(first_href - vfall), 32'(VB * HT));

    // Frame 3: switch to gradient at line 20; this frame must stay bars
    capture(1'b0, 20, 1, 2'd1, 4, "f3_latch", w);
    chk("period_next_vsync_rise", 32'(w), 1);
    chk("latch_y30_x0", pix[30][0], 255);
    chk("latch_y31_x49", pix[31][49], 0);
    chk("latch_y40_x9", pix[40][9], 255);

    // Frame 4: gradient; request moving box for the next frame
    capture(1'b0, 10, 1, 2'd2, 5, "f4_grad", w);
    chk("grad_y0_x44", pix[0][44], 44);
    chk("grad_y0_x0", pix[0][0], 0);
    chk("grad_y5_x63", pix[5][63], 63);

    // Frame 5: box wrapped from 48 back to 0; drop enable at active line 10
    capture(1'b0, 10, 2, 2'd0, 6, "f5_stop", w);
    chk("stop_href_pulses", 32'(pulses), 32'(VD));
    chk("wrap_y20_x0", pix[20][0], 240);
    chk("wrap_y20_x8", pix[20][8], 16);

    n_vs = 0; n_hr = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (post_frame_vsync) n_vs++;
      if (post_frame_href) n_hr++;
    end
    chk("idle_after_stop_vsync", 32'(n_vs), 0);
    chk("idle_after_stop_href", 32'(n_hr), 0);
    chk("idle_after_stop_frame_cnt", 32'(frame_cnt), 6);

    // Reset in the middle of an active line
    enable = 1'b1;
    w = 0;
    while (!post_frame_href && w < 2 * FRAME) begin
      @(negedge clk);
      w++;
    end
    chk("wait_href_for_reset", 32'(post_frame_href), 1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midline_reset_vsync", 32'(post_frame_vsync), 0);
    chk("midline_reset_href", 32'(post_frame_href), 0);
    chk("midline_reset_raw", 32'(post_img_RAW), 0);
    chk("midline_reset_frame_cnt", 32'(frame_cnt), 0);
    rst_n = 1'b1;
    check_start("restart");
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
